// File: rtl/bb_pkg.sv
// -----------------------------------------------------------------------------
// bb_pkg
// Shared definitions for the bridge-channel pulse generator:
//   - default counter widths (phase timer and bipolar cycle counter)
//   - FSM state encoding
//   - busy-state decode helper shared by next-state and output logic
// -----------------------------------------------------------------------------
package bb_pkg;

    // Default width of the pulse-width / dead-time / df-length counters.
    localparam int unsigned DEF_CNT_W = 16;
    // Default width of the bipolar cycle-count input and counter.
    localparam int unsigned DEF_NUM_W = 8;

    // Sequencer states. IDLE waits for start, FWD/DT1/BACK/DT2 form one
    // bipolar cycle, DFP is the discharge pulse and FIN the done cycle.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FWD  = 3'd1,
        ST_DT1  = 3'd2,
        ST_BACK = 3'd3,
        ST_DT2  = 3'd4,
        ST_DFP  = 3'd5,
        ST_FIN  = 3'd6
    } bb_state_e;

    // A sequence is "in flight" (busy, abortable) in every state between
    // IDLE and FIN, exclusive of both.
    function automatic logic is_active(input bb_state_e s);
        return (s == ST_FWD) || (s == ST_DT1) || (s == ST_BACK) ||
               (s == ST_DT2) || (s == ST_DFP);
    endfunction

endpackage

// File: rtl/bb_phase_cnt.sv
// -----------------------------------------------------------------------------
// bb_phase_cnt
// Loadable down-counter with terminal-count flag.
//
// The owner loads (length - 1) when entering a phase and asserts en_i on
// every cycle the phase continues; the phase ends in the cycle where tc_o is
// high. The counter saturates at zero so it can never wrap, which keeps the
// full 2^W - 1 range usable.
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset (count -> 0)
//   load_i      in   load load_val_i (takes priority over en_i)
//   load_val_i  in   W-bit value to load
//   en_i        in   decrement enable
//   tc_o        out  terminal count: count is zero
// -----------------------------------------------------------------------------
module bb_phase_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    localparam logic [W-1:0] CNT_ONE = W'(1);

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            // Saturating decrement: holding at zero prevents underflow.
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/bb_pulse_gen.sv
// -----------------------------------------------------------------------------
// bb_pulse_gen
// Forward / back / df drive waveform generator for one source set of the
// bridge-channel selector.
//
// On an accepted start it emits num bipolar cycles
//   forward (pw) -> dead (dt) -> back (pw) -> dead (dt)
// followed by one df discharge pulse (df_len), then a one-cycle done.
// Configuration is latched at start; later input changes are ignored until
// the next start. All outputs come straight from flip-flops.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   start   in   one-cycle request, sampled only in IDLE
//   abort   in   cancels a sequence in flight (no done); no effect in IDLE
//   pw      in   forward/back pulse width in cycles
//   dt      in   dead time in cycles (0 skips dead-time phases)
//   df_len  in   discharge pulse width in cycles (0 skips df)
//   num     in   number of bipolar cycles (0 -> df only)
//   forward out  forward drive
//   back    out  back drive
//   df      out  discharge drive
//   busy    out  sequence in flight
//   done    out  one-cycle pulse at normal completion
// -----------------------------------------------------------------------------
module bb_pulse_gen
    import bb_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int NUM_W = DEF_NUM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] pw,
    input  logic [CNT_W-1:0] dt,
    input  logic [CNT_W-1:0] df_len,
    input  logic [NUM_W-1:0] num,
    output logic             forward,
    output logic             back,
    output logic             df,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [NUM_W-1:0] NUM_ONE = NUM_W'(1);

    // FSM state
    bb_state_e state_q;
    bb_state_e state_d;

    // Latched configuration. The bipolar cycle count lives in the cycle
    // counter itself, so no separate copy of num is kept.
    logic [CNT_W-1:0] pw_q;
    logic [CNT_W-1:0] dt_q;
    logic [CNT_W-1:0] df_len_q;
    logic             cfg_latch;

    // Phase timer control
    logic             ph_load;
    logic [CNT_W-1:0] ph_val;
    logic             ph_en;
    logic             ph_tc;

    // Cycle counter control
    logic             cyc_load;
    logic [NUM_W-1:0] cyc_val;
    logic             cyc_en;
    logic             cyc_tc;

    // Set when a bipolar cycle finishes (end of DT2, or end of BACK when the
    // dead time is zero); the follow-on decision is shared by both paths.
    logic             cyc_end;

    // Registered outputs and their next-state values
    logic forward_q, back_q, df_q, busy_q, done_q;
    logic forward_d, back_d, df_d, busy_d, done_d;

    // -------------------------------------------------------------------------
    // Counters
    // -------------------------------------------------------------------------
    bb_phase_cnt #(
        .W (CNT_W)
    ) u_phase_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ph_load),
        .load_val_i (ph_val),
        .en_i       (ph_en),
        .tc_o       (ph_tc)
    );

    bb_phase_cnt #(
        .W (NUM_W)
    ) u_cycle_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cyc_load),
        .load_val_i (cyc_val),
        .en_i       (cyc_en),
        .tc_o       (cyc_tc)
    );

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cfg_latch = 1'b0;
        ph_load   = 1'b0;
        ph_val    = '0;
        ph_en     = 1'b0;
        cyc_load  = 1'b0;
        cyc_val   = '0;
        cyc_en    = 1'b0;
        cyc_end   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Raw inputs are used here because the latched copies
                    // only become valid on this same edge.
                    cfg_latch = 1'b1;
                    cyc_load  = 1'b1;
                    cyc_val   = (num == '0) ? '0 : (num - NUM_ONE);
                    if ((num != '0) && (pw != '0)) begin
                        state_d = ST_FWD;
                        ph_load = 1'b1;
                        ph_val  = pw - CNT_ONE;
                    end else if (df_len != '0) begin
                        state_d = ST_DFP;
                        ph_load = 1'b1;
                        ph_val  = df_len - CNT_ONE;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end

            ST_FWD: begin
                if (ph_tc) begin
                    ph_load = 1'b1;
                    if (dt_q != '0) begin
                        state_d = ST_DT1;
                        ph_val  = dt_q - CNT_ONE;
                    end else begin
                        state_d = ST_BACK;
                        ph_val  = pw_q - CNT_ONE;
                    end
                end else begin
                    ph_en = 1'b1;
                end
            end

            ST_DT1: begin
                if (ph_tc) begin
                    state_d = ST_BACK;
                    ph_load = 1'b1;
                    ph_val  = pw_q - CNT_ONE;
                end else begin
                    ph_en = 1'b1;
                end
            end

            ST_BACK: begin
                if (ph_tc) begin
                    if (dt_q != '0) begin
                        state_d = ST_DT2;
                        ph_load = 1'b1;
                        ph_val  = dt_q - CNT_ONE;
                    end else begin
                        cyc_end = 1'b1;
                    end
                end else begin
                    ph_en = 1'b1;
                end
            end

            ST_DT2: begin
                if (ph_tc) begin
                    cyc_end = 1'b1;
                end else begin
                    ph_en = 1'b1;
                end
            end

            ST_DFP: begin
                if (ph_tc) begin
                    state_d = ST_FIN;
                end else begin
                    ph_en = 1'b1;
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // End of a bipolar cycle: the cycle counter holds (cycles left - 1),
        // so terminal count means this was the last one.
        if (cyc_end) begin
            if (!cyc_tc) begin
                cyc_en  = 1'b1;
                state_d = ST_FWD;
                ph_load = 1'b1;
                ph_val  = pw_q - CNT_ONE;
            end else if (df_len_q != '0) begin
                state_d = ST_DFP;
                ph_load = 1'b1;
                ph_val  = df_len_q - CNT_ONE;
            end else begin
                state_d = ST_FIN;
            end
        end

        // Abort only cancels a sequence in flight; in IDLE a coincident
        // start still wins.
        if (abort && is_active(state_q)) begin
            state_d  = ST_IDLE;
            ph_load  = 1'b0;
            ph_en    = 1'b0;
            cyc_load = 1'b0;
            cyc_en   = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Output decode (from next state, registered below)
    // -------------------------------------------------------------------------
    always_comb begin
        forward_d = (state_d == ST_FWD);
        back_d    = (state_d == ST_BACK);
        df_d      = (state_d == ST_DFP);
        busy_d    = is_active(state_d);
        done_d    = (state_d == ST_FIN);
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            forward_q <= 1'b0;
            back_q    <= 1'b0;
            df_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            forward_q <= forward_d;
            back_q    <= back_d;
            df_q      <= df_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Configuration latch
    always_ff @(posedge clk) begin
        if (rst) begin
            pw_q     <= '0;
            dt_q     <= '0;
            df_len_q <= '0;
        end else if (cfg_latch) begin
            pw_q     <= pw;
            dt_q     <= dt;
            df_len_q <= df_len;
        end
    end

    assign forward = forward_q;
    assign back    = back_q;
    assign df      = df_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
